// File: rtl/if_stage_pkg.sv
// Shared constants and FSM state type for the instruction-fetch stage.
package if_stage_pkg;
  localparam int unsigned       INST_W           = 32;
  localparam logic [31:0]       PC_RESET_DEFAULT = 32'h0000_0000;
  localparam logic [INST_W-1:0] NOP_INST         = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FULL = 2'd2
  } if_state_e;
endpackage

// File: rtl/if_stage_pc_reg.sv
// Next-fetch program counter: redirect target (word-aligned) or sequential increment.
module if_stage_pc_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        seq_load_i,
  input  logic [31:0] seq_base_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_next_o
);
  logic [31:0] pc_q, pc_d;
  logic [1:0]  unused_redirect_lsbs;

  assign unused_redirect_lsbs = redirect_pc_i[1:0];

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid_i)  pc_d = {redirect_pc_i[31:2], 2'b00};
    else if (seq_load_i)   pc_d = seq_base_i + 32'd4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= PC_RESET;
    else        pc_q <= pc_d;
  end

  assign pc_o      = pc_q;
  assign pc_next_o = pc_d;
endmodule

// File: rtl/if_stage.sv
// Instruction fetch: one outstanding imem request, one-entry buffer toward decode,
// redirects squash the buffer or kill the in-flight response.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [INST_W-1:0] inst,
  output logic [31:0]       inst_pc,
  output logic [31:0]       pc_plus4,
  output logic              inst_valid,
  input  logic              inst_ready
);
  if_stage_pkg::if_state_e state_q, state_d;
  logic [31:0]       fetch_addr_q, fetch_addr_d;
  logic              kill_q, kill_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [31:0]       inst_pc_q, inst_pc_d;
  logic              inst_valid_q, inst_valid_d;
  logic              seq_load;
  logic [31:0]       pc, pc_next;

  if_stage_pc_reg #(.PC_RESET(PC_RESET)) u_pc_reg (
    .clk              (clk),
    .rst_n            (rst_n),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .seq_load_i       (seq_load),
    .seq_base_i       (fetch_addr_q),
    .pc_o             (pc),
    .pc_next_o        (pc_next)
  );

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    kill_d       = kill_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    seq_load     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Use the post-redirect pc so a same-cycle redirect is not fetched down the stale path.
        fetch_addr_d = redirect_valid ? pc_next : pc;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_ack) begin
          if (kill_q || redirect_valid) begin
            kill_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            inst_d       = imem_rdata;
            inst_pc_d    = fetch_addr_q;
            inst_valid_d = 1'b1;
            seq_load     = 1'b1;
            state_d      = ST_FULL;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
        end
      end
      ST_FULL: begin
        if (redirect_valid || inst_ready) begin
          inst_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      fetch_addr_q <= PC_RESET;
      kill_q       <= 1'b0;
      inst_q       <= NOP_INST;
      inst_pc_q    <= PC_RESET;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      kill_q       <= kill_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign imem_req   = (state_q == ST_WAIT);
  assign imem_addr  = fetch_addr_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;
  assign pc_plus4   = inst_pc_q + 32'd4;
endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table, random run against a
// transaction-level model, pc wrap instance, and asynchronous reset mid-request.
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack, redirect_valid, inst_valid, inst_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, inst, inst_pc, pc_plus4;

  logic        rst_w_n, req_w, ack_w, valid_w, ready_w;
  logic [31:0] addr_w, rdata_w, inst_w, ipc_w, pc4_w;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst(inst), .inst_pc(inst_pc), .pc_plus4(pc_plus4),
    .inst_valid(inst_valid), .inst_ready(inst_ready)
  );

  if_stage #(.PC_RESET(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_w_n), .imem_req(req_w), .imem_addr(addr_w),
    .imem_ack(ack_w), .imem_rdata(rdata_w), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .inst(inst_w), .inst_pc(ipc_w), .pc_plus4(pc4_w),
    .inst_valid(valid_w), .inst_ready(ready_w)
  );

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: an outstanding request, a buffered instruction, the next pc.
  logic        m_req, m_valid, m_kill;
  logic [31:0] m_addr, m_pc, m_inst, m_ipc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rv, input logic [31:0] rp, input logic ak, input logic [31:0] rd,
                     input logic rdy, input logic er, input logic [31:0] ea, input logic ev,
                     input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v.redir = rv; v.rpc = rp; v.ack = ak; v.rdata = rd; v.ready = rdy;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_inst = ei; v.e_ipc = ep;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic rv, input logic [31:0] rp, input logic ak,
                       input logic [31:0] rd, input logic rdy);
    redirect_valid = rv; redirect_pc = rp; imem_ack = ak; imem_rdata = rd; inst_ready = rdy;
  endtask

  task automatic model_reset();
    m_req = 1'b0; m_valid = 1'b0; m_kill = 1'b0;
    m_addr = 32'h0; m_pc = 32'h0; m_inst = NOP; m_ipc = 32'h0;
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    tgt = {redirect_pc[31:2], 2'b00};
    if (!m_req && !m_valid) begin
      m_addr = redirect_valid ? tgt : m_pc;
      m_req  = 1'b1;
    end else if (m_req) begin
      if (imem_ack) begin
        m_req = 1'b0;
        if (!m_kill && !redirect_valid) begin
          m_valid = 1'b1; m_inst = imem_rdata; m_ipc = m_addr; m_pc = m_addr + 32'd4;
        end
        m_kill = 1'b0;
      end else if (redirect_valid) begin
        m_kill = 1'b1;
      end
    end else if (redirect_valid || inst_ready) begin
      m_valid = 1'b0;
    end
    if (redirect_valid) m_pc = tgt;
  endtask

  task automatic model_check();
    chk("req", {31'b0, imem_req}, {31'b0, m_req});
    if (m_req) chk("addr", imem_addr, m_addr);
    chk("valid", {31'b0, inst_valid}, {31'b0, m_valid});
    chk("inst", inst, m_inst);
    chk("inst_pc", inst_pc, m_ipc);
    chk("pc_plus4", pc_plus4, m_ipc + 32'd4);
  endtask

  task automatic chk_reset_vals();
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_inst", inst, NOP);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n = 1'b0; rst_w_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    ack_w = 1'b0; rdata_w = 32'h0; ready_w = 1'b0;

    //   redir rpc          ack rdata          rdy | req addr         vld inst           ipc
    add(0, 32'h0,   0, 32'h0,        0,  1, 32'h0,   0, NOP,           32'h0);
    add(0, 32'h0,   1, 32'h00500093, 0,  0, 32'h0,   1, 32'h00500093,  32'h0);
    for (int i = 0; i < 5; i++)
      add(0, 32'h0, 0, 32'h0,        0,  0, 32'h0,   1, 32'h00500093,  32'h0);
    add(0, 32'h0,   0, 32'h0,        1,  0, 32'h0,   0, 32'h00500093,  32'h0);
    add(0, 32'h0,   0, 32'h0,        0,  1, 32'h4,   0, 32'h00500093,  32'h0);
    add(0, 32'h0,   1, 32'h00100113, 0,  0, 32'h0,   1, 32'h00100113,  32'h4);
    add(0, 32'h0,   0, 32'h0,        1,  0, 32'h0,   0, 32'h00100113,  32'h4);
    add(0, 32'h0,   0, 32'h0,        0,  1, 32'h8,   0, 32'h00100113,  32'h4);
    add(1, 32'h40,  0, 32'h0,        0,  1, 32'h8,   0, 32'h00100113,  32'h4);
    add(0, 32'h0,   0, 32'h0,        0,  1, 32'h8,   0, 32'h00100113,  32'h4);
    add(0, 32'h0,   1, 32'hDEADBEEF, 0,  0, 32'h0,   0, 32'h00100113,  32'h4);
    add(0, 32'h0,   0, 32'h0,        0,  1, 32'h40,  0, 32'h00100113,  32'h4);
    add(0, 32'h0,   1, 32'h00000513, 0,  0, 32'h0,   1, 32'h00000513,  32'h40);
    add(1, 32'h103, 0, 32'h0,        1,  0, 32'h0,   0, 32'h00000513,  32'h40);
    add(0, 32'h0,   0, 32'h0,        0,  1, 32'h100, 0, 32'h00000513,  32'h40);
    add(0, 32'h0,   1, 32'h00a00593, 0,  0, 32'h0,   1, 32'h00a00593,  32'h100);
    add(0, 32'h0,   0, 32'h0,        1,  0, 32'h0,   0, 32'h00a00593,  32'h100);

    do_reset();
    foreach (tbl[i]) begin
      drive(tbl[i].redir, tbl[i].rpc, tbl[i].ack, tbl[i].rdata, tbl[i].ready);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].e_req});
      if (tbl[i].e_req) chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_valid", i), {31'b0, inst_valid}, {31'b0, tbl[i].e_valid});
      chk($sformatf("v%0d_inst", i), inst, tbl[i].e_inst);
      chk($sformatf("v%0d_inst_pc", i), inst_pc, tbl[i].e_ipc);
      chk($sformatf("v%0d_pc_plus4", i), pc_plus4, tbl[i].e_ipc + 32'd4);
    end

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      drive($urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 9) < 4, $urandom,
            $urandom_range(0, 1) == 1);
      @(posedge clk);
      model_step();
      @(negedge clk);
      model_check();
    end

    // Reset asserted while a request is outstanding drops it immediately.
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    for (int c = 0; c < 6 && !m_req; c++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
    chk("pre_rst_req", {31'b0, imem_req}, 32'h1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals();
    drive(1'b0, 32'h0, 1'b1, 32'hBADC0DE0, 1'b1);
    repeat (2) @(negedge clk);
    chk_reset_vals();
    model_reset();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      drive($urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 1) == 1, $urandom,
            $urandom_range(0, 1) == 1);
      @(posedge clk);
      model_step();
      @(negedge clk);
      model_check();
    end

    // pc wraps from 32'hFFFF_FFFC to 0.
    rst_w_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("wrap_req0", {31'b0, req_w}, 32'h1);
    chk("wrap_addr0", addr_w, 32'hFFFF_FFFC);
    ack_w = 1'b1; rdata_w = 32'h0000_0013;
    @(posedge clk); @(negedge clk);
    ack_w = 1'b0;
    chk("wrap_valid", {31'b0, valid_w}, 32'h1);
    chk("wrap_inst_pc", ipc_w, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", pc4_w, 32'h0);
    ready_w = 1'b1;
    @(posedge clk); @(negedge clk);
    ready_w = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("wrap_req1", {31'b0, req_w}, 32'h1);
    chk("wrap_addr1", addr_w, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port imem_req  out  1  instruction-memory request, held until acknowledged.
REQ-005 SHALL have port imem_addr  out  32  word-aligned fetch address, stable while imem_req=1.
REQ-006 SHALL have port imem_ack  in  1  memory accepts the request and returns data this cycle.
REQ-007 SHALL have port imem_rdata  in  32  instruction word, valid when imem_ack=1.
REQ-008 SHALL have port redirect_valid  in  1  taken branch or jal from the execute path.
REQ-009 SHALL have port redirect_pc  in  32  redirect target.
REQ-010 SHALL have port inst  out  32  buffered instruction to decode (opcode = inst[6:0]).
REQ-011 SHALL have port inst_pc  out  32  address of inst.
REQ-012 SHALL have port pc_plus4  out  32  inst_pc+4, link value for jal write-back.
REQ-013 SHALL have port inst_valid  out  1  inst/inst_pc are meaningful.
REQ-014 SHALL have port inst_ready  in  1  decode consumes inst this cycle when inst_valid=1.

Function
REQ-015 SHALL hold pc (next fetch address), fetch_addr, one-entry instruction buffer, kill flag, and a 3-state FSM: IDLE, WAIT, FULL.
REQ-016 IDLE: imem_req=0; fetch_addr<=pc; next state WAIT.
REQ-017 WAIT: imem_req=1, imem_addr=fetch_addr; with no imem_ack, stay in WAIT.
REQ-018 WAIT with imem_ack, kill=0 and redirect_valid=0: inst<=imem_rdata, inst_pc<=fetch_addr, inst_valid<=1, pc<=fetch_addr+4, next state FULL.
REQ-019 WAIT with imem_ack and (kill=1 or redirect_valid=1): discard the data, clear kill, next state IDLE.
REQ-020 FULL: imem_req=0, inst_valid=1; on inst_ready and no redirect, inst_valid<=0 and next state IDLE.
REQ-021 redirect_valid in any state SHALL set pc<={redirect_pc[31:2],2'b00}; redirect_pc[1:0] is ignored.
REQ-022 redirect_valid in FULL SHALL clear inst_valid and go to IDLE, even when inst_ready=1 in the same cycle.
REQ-023 redirect_valid in WAIT without imem_ack SHALL set kill=1; imem_req and imem_addr stay unchanged until ack.
REQ-024 A redirect in the same cycle as a kill-discarding ack SHALL still update pc; the latest redirect wins.
REQ-025 pc and fetch_addr arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 32'h0000_0000.
REQ-026 pc_plus4 SHALL be combinational inst_pc+4 (same wrap).
REQ-027 Minimum latency SHALL be: request 1 cycle after IDLE, inst_valid 1 cycle after ack; throughput at most one instruction per 3 cycles.

Reset
REQ-028 While rst_n=0: state=IDLE, pc=PC_RESET, fetch_addr=PC_RESET, kill=0, inst_valid=0, inst=32'h0000_0013 (nop), inst_pc=PC_RESET, imem_req=0.
REQ-029 Reset asserted mid-WAIT SHALL drop the outstanding request immediately; no data is accepted afterwards until a new request.

Structure
REQ-030 A shared package SHALL hold PC_RESET default, NOP_INST=32'h0000_0013, INST_W=32, and the FSM state enum.
REQ-031 A pc_reg sub-module (pc register with increment and redirect select) SHALL be used; the remaining logic stays in if_stage.

Verification
REQ-032 Reset release, imem_ack on the first WAIT cycle with rdata=32'h00500093 -> imem_addr=0, then inst=32'h00500093, inst_pc=0, pc_plus4=4.
REQ-033 inst_ready=0 for 5 cycles in FULL -> inst/inst_valid stable, imem_req=0, no pc advance; ready=1 -> next request at addr 4.
REQ-034 redirect_pc=32'h40 during WAIT at addr 8, ack 2 cycles later -> data discarded, inst_valid stays 0, next request at 32'h40.
REQ-035 redirect_pc=32'h103 in FULL with inst_ready=1 -> buffer squashed, next imem_addr=32'h100.
REQ-036 PC_RESET=32'hFFFF_FFFC, one fetch -> second request at 32'h0000_0000.
REQ-037 rst_n low while imem_req=1 -> imem_req=0 the same cycle; outputs return to REQ-028 values.
